control_sequencer: RTL and testbench

Hardwired control unit for the 3-bus RISC datapath. Steps a Moore FSM through the fetch (T0–T2) and execute (T3–T6) phases, producing the bus-drive, register-load and ALU-select strobes that `DataPath` consumes. This replaces hand-sequenced control. It is parametrised in register count and data width, supports unary and two-result (MUL/DIV) instructions, and reports run/halt/illegal status.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/control_sequencer_if.sv | 50 +++++
 rtl/ir_decoder.sv | 89 ++++++++
 rtl/control_sequencer.sv | 140 ++++++++++++++
 tb/tb_control_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, FSM states, instruction classes
// and IR field offset helpers for control_sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_BIN,
    C_UNARY,
    C_MULDIV,
    C_NOP,
    C_HALT,
    C_ILL
  } cls_e;

  // Fields are packed directly below the opcode: Ra, Rb, Rc
  function automatic int opc_lsb(int dw, int ow);
    return dw - ow;
  endfunction

  function automatic int ra_lsb(int dw, int ow, int aw);
    return dw - ow - aw;
  endfunction

  function automatic int rb_lsb(int dw, int ow, int aw);
    return dw - ow - 2 * aw;
  endfunction

  function automatic int rc_lsb(int dw, int ow, int aw);
    return dw - ow - 3 * aw;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the sequencer
// (master) and the datapath (slave).
interface control_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int NUM_REGS = 16
);
  logic                Start;
  logic [DATA_W-1:0]   IR;
  logic                Run;
  logic                Illegal;
  logic                PCout;
  logic                PCin;
  logic                IncPC;
  logic                MARin;
  logic                Read;
  logic                MDRin;
  logic                MDRout;
  logic                IRin;
  logic                Yin;
  logic                ZLowIn;
  logic                ZHighIn;
  logic                Zlowout;
  logic                ZHighout;
  logic                HIin;
  logic                LOin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [OPC_W-1:0]    ALU_op;

  modport master (
    input  Start, IR,
    output Run, Illegal,
    output PCout, PCin, IncPC, MARin,
    output Read, MDRin, MDRout, IRin, Yin,
    output ZLowIn, ZHighIn, Zlowout, ZHighout,
    output HIin, LOin,
    output Rin, Rout, ALU_op
  );

  modport slave (
    output Start, IR,
    input  Run, Illegal,
    input  PCout, PCin, IncPC, MARin,
    input  Read, MDRin, MDRout, IRin, Yin,
    input  ZLowIn, ZHighIn, Zlowout, ZHighout,
    input  HIin, LOin,
    input  Rin, Rout, ALU_op
  );
endinterface

// File: rtl/ir_decoder.sv
// Combinational IR decode to class, fields, legality.
// MUL/DIV decode only with CTRL_MULDIV_EN defined.
module ir_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [OPC_W-1:0]  opc,
  output cls_e              cls,
  output logic [REG_AW-1:0] ra,
  output logic [REG_AW-1:0] rb,
  output logic [REG_AW-1:0] rc,
  output logic              legal
);

  localparam int OL  = opc_lsb(DATA_W, OPC_W);
  localparam int RAL = ra_lsb(DATA_W, OPC_W, REG_AW);
  localparam int RBL = rb_lsb(DATA_W, OPC_W, REG_AW);
  localparam int RCL = rc_lsb(DATA_W, OPC_W, REG_AW);

`ifdef CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic ra_ok;
  logic rb_ok;
  logic rc_ok;

  assign opc = ir[OL  +: OPC_W];
  assign ra  = ir[RAL +: REG_AW];
  assign rb  = ir[RBL +: REG_AW];
  assign rc  = ir[RCL +: REG_AW];

  assign ra_ok = 32'(ra) < 32'(NUM_REGS);
  assign rb_ok = 32'(rb) < 32'(NUM_REGS);
  assign rc_ok = 32'(rc) < 32'(NUM_REGS);

  generate
    if (RCL > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^ir[RCL-1:0];
    end
  endgenerate

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      opc == OPC_W'(OP_ADD) ||
      opc == OPC_W'(OP_SUB) ||
      opc == OPC_W'(OP_AND) ||
      opc == OPC_W'(OP_OR)  ||
      opc == OPC_W'(OP_SHR) ||
      opc == OPC_W'(OP_SHL):
        cls = C_BIN;
      opc == OPC_W'(OP_NEG) ||
      opc == OPC_W'(OP_NOT):
        cls = C_UNARY;
      MD_EN && (opc == OPC_W'(OP_MUL) ||
                opc == OPC_W'(OP_DIV)):
        cls = C_MULDIV;
      opc == OPC_W'(OP_NOP):
        cls = C_NOP;
      opc == OPC_W'(OP_HALT):
        cls = C_HALT;
      default:
        cls = C_ILL;
    endcase
  end

  // Only fields the class actually reads can make it illegal
  always_comb begin
    legal = 1'b0;
    unique case (cls)
      C_BIN:    legal = ra_ok && rb_ok && rc_ok;
      C_UNARY:  legal = ra_ok && rb_ok;
      C_MULDIV: legal = rb_ok && rc_ok;
      C_NOP:    legal = 1'b1;
      C_HALT:   legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the 3-bus datapath.
// CTRL_MULDIV_EN enables MUL/DIV (T6, HIin, LOin).
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  state_e            state;
  cls_e              cls_d;
  cls_e              cls_q;
  logic [OPC_W-1:0]  opc_d;
  logic [OPC_W-1:0]  opc_q;
  logic [REG_AW-1:0] ra_d, rb_d, rc_d;
  logic [REG_AW-1:0] ra_q, rb_q, rc_q;
  logic              legal;

  ir_decoder #(
    .DATA_W   (DATA_W),
    .OPC_W    (OPC_W),
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .ir    (bus.IR),
    .opc   (opc_d),
    .cls   (cls_d),
    .ra    (ra_d),
    .rb    (rb_d),
    .rc    (rc_d),
    .legal (legal)
  );

  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [REG_AW-1:0] idx
  );
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      v[i] = (32'(idx) == 32'(i));
    return v;
  endfunction

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= S_IDLE;
      cls_q <= C_NOP;
      opc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      if (state == S_T2) begin
        cls_q <= cls_d;
        opc_q <= opc_d;
        ra_q  <= ra_d;
        rb_q  <= rb_d;
        rc_q  <= rc_d;
      end
      unique case (state)
        S_IDLE, S_HALT:
          if (bus.Start) state <= S_T0;
        S_T0: state <= S_T1;
        S_T1: state <= S_T2;
        S_T2:
          if (!legal || cls_d == C_NOP)
            state <= S_T0;
          else if (cls_d == C_HALT)
            state <= S_HALT;
          else if (cls_d == C_UNARY)
            state <= S_T4;
          else
            state <= S_T3;
        S_T3: state <= S_T4;
        S_T4: state <= S_T5;
        S_T5: begin
`ifdef CTRL_MULDIV_EN
          state <= (cls_q == C_MULDIV) ? S_T6 : S_T0;
`else
          state <= S_T0;
`endif
        end
        S_T6: state <= S_T0;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic t0, t1, t2, t3, t4, t5, t6;
  logic alu_cls;

  assign t0 = state == S_T0;
  assign t1 = state == S_T1;
  assign t2 = state == S_T2;
  assign t3 = state == S_T3;
  assign t4 = state == S_T4;
  assign t5 = state == S_T5;
  assign t6 = state == S_T6;
  assign alu_cls = cls_q == C_BIN || cls_q == C_UNARY;

  assign bus.Run = t0 | t1 | t2 | t3 | t4 | t5 | t6;
  assign bus.Illegal = t2 && !legal;
  assign bus.PCout = t0;
  assign bus.MARin = t0;
  assign bus.IncPC = t0;
  assign bus.PCin = t0;
  assign bus.Read = t1;
  assign bus.MDRin = t1;
  assign bus.MDRout = t2;
  assign bus.IRin = t2;
  assign bus.Yin = t3;
  assign bus.ZLowIn = t4;
  assign bus.ZHighIn = t4;
  assign bus.Zlowout = t5;
  assign bus.ZHighout = t6;
  assign bus.ALU_op = t4 ? opc_q : '0;

`ifdef CTRL_MULDIV_EN
  assign bus.LOin = t5 && cls_q == C_MULDIV;
  assign bus.HIin = t6;
`else
  assign bus.LOin = 1'b0;
  assign bus.HIin = 1'b0;
`endif

  // Unary ops drive their single source (Rb) in T4
  assign bus.Rout =
    t3 ? onehot(rb_q) :
    t4 ? onehot(cls_q == C_UNARY ? rb_q : rc_q) :
    '0;
  assign bus.Rin =
    (t5 && alu_cls) ? onehot(ra_q) : '0;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level model
// plus directed literal and Clear checks.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  control_sequencer_if #(
    .DATA_W   (32),
    .OPC_W    (5),
    .NUM_REGS (16)
  ) bus ();

  control_sequencer #(
    .DATA_W   (32),
    .OPC_W    (5),
    .REG_AW   (4),
    .NUM_REGS (16)
  ) dut (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus)
  );

`ifdef CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic run, ill;
    logic pcout, pcin, incpc, marin;
    logic rd, mdrin, mdrout, irin, yin;
    logic zli, zhi, zlo, zho, hiin, loin;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
  } snap_t;

  typedef struct packed {
    logic        start;
    logic [31:0] ir;
  } stim_t;

  snap_t got;
  snap_t log_q[$];
  snap_t exp_q[$];
  stim_t stim_q[$];
  int checks = 0;
  int errors = 0;

  always_comb begin
    got = '0;
    got.run = bus.Run;
    got.ill = bus.Illegal;
    got.pcout = bus.PCout;
    got.pcin = bus.PCin;
    got.incpc = bus.IncPC;
    got.marin = bus.MARin;
    got.rd = bus.Read;
    got.mdrin = bus.MDRin;
    got.mdrout = bus.MDRout;
    got.irin = bus.IRin;
    got.yin = bus.Yin;
    got.zli = bus.ZLowIn;
    got.zhi = bus.ZHighIn;
    got.zlo = bus.Zlowout;
    got.zho = bus.ZHighout;
    got.hiin = bus.HIin;
    got.loin = bus.LOin;
    got.rin = bus.Rin;
    got.rout = bus.Rout;
    got.alu = bus.ALU_op;
  end

  task automatic chk(input string nm,
                     input logic [63:0] g,
                     input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask

  function automatic void push(input logic st,
                               input logic [31:0] ir,
                               input snap_t s);
    stim_t t;
    t.start = st;
    t.ir = ir;
    stim_q.push_back(t);
    exp_q.push_back(s);
  endfunction

  function automatic void add_wait(input int n,
                                   input logic st);
    for (int i = 0; i < n; i++) push(st, 32'h0, '0);
  endfunction

  // Expected per-cycle micro-ops of one instruction
  function automatic int add_instr(input logic [31:0] ir,
                                   input logic st);
    int op, ra, rb, rc, n0;
    bit bin, un, md, nop, hlt, ill;
    snap_t s;
    op = int'(ir >> 27);
    ra = int'((ir >> 23) & 32'hF);
    rb = int'((ir >> 19) & 32'hF);
    rc = int'((ir >> 15) & 32'hF);
    bin = op >= 3 && op <= 8;
    un = op == 17 || op == 18;
    md = MD_EN && (op == 15 || op == 16);
    nop = op == 26;
    hlt = op == 27;
    ill = !(bin || un || md || nop || hlt);
    n0 = stim_q.size();
    s = '0; s.run = 1;
    s.pcout = 1; s.marin = 1; s.incpc = 1; s.pcin = 1;
    push(st, ir, s);
    s = '0; s.run = 1; s.rd = 1; s.mdrin = 1;
    push(st, ir, s);
    s = '0; s.run = 1; s.mdrout = 1; s.irin = 1;
    s.ill = ill;
    push(st, ir, s);
    if (bin || md) begin
      s = '0; s.run = 1; s.yin = 1;
      s.rout = 16'(1) << rb;
      push(st, ir, s);
    end
    if (bin || un || md) begin
      s = '0; s.run = 1; s.zli = 1; s.zhi = 1;
      s.alu = 5'(op);
      s.rout = 16'(1) << (un ? rb : rc);
      push(st, ir, s);
      s = '0; s.run = 1; s.zlo = 1;
      if (md) s.loin = 1;
      else s.rin = 16'(1) << ra;
      push(st, ir, s);
    end
    if (md) begin
      s = '0; s.run = 1; s.zho = 1; s.hiin = 1;
      push(st, ir, s);
    end
    return stim_q.size() - n0;
  endfunction

  task automatic play();
    stim_t s;
    snap_t e;
    int cyc;
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.Start = s.start;
      bus.IR = s.ir;
      @(negedge clk);
      log_q.push_back(got);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cyc %0d: got %h expected %h",
                 cyc, got, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b_or, b_neg, b_mul, b_ill, b_h1, b_not;
    clr = 1'b0;
    bus.Start = 1'b0;
    bus.IR = '0;
    #1 clr = 1'b1;
    #2 chk("reset_outs", 64'(got), 64'h0);
    @(posedge clk);
    #1 clr = 1'b0;

    add_wait(3, 1'b0);
    add_wait(1, 1'b1);
    b_or = stim_q.size();
    n = add_instr(32'h321B8000, 1'b0);
    chk("len_or", 64'(n), 64'd6);
    b_neg = stim_q.size();
    n = add_instr(32'h8AC80000, 1'b0);
    chk("len_neg", 64'(n), 64'd5);
    n = add_instr(32'h18978000, 1'b0);
    chk("len_add", 64'(n), 64'd6);
    b_mul = stim_q.size();
    n = add_instr(32'h781B8000, 1'b0);
`ifdef CTRL_MULDIV_EN
    chk("len_mul", 64'(n), 64'd7);
`else
    chk("len_mul", 64'(n), 64'd3);
`endif
    n = add_instr(32'hD0000000, 1'b0);
    chk("len_nop", 64'(n), 64'd3);
    b_ill = stim_q.size();
    n = add_instr(32'hF8000000, 1'b0);
    chk("len_ill", 64'(n), 64'd3);
    b_h1 = stim_q.size();
    n = add_instr(32'hD8000000, 1'b1);
    chk("len_halt", 64'(n), 64'd3);
    add_wait(2, 1'b0);
    add_wait(1, 1'b1);
    b_not = stim_q.size();
    n = add_instr(32'h91180000, 1'b0);
    chk("len_not", 64'(n), 64'd5);
    void'(add_instr(32'hD8000000, 1'b0));
    add_wait(2, 1'b0);

    play();

    chk("or_t3_rout", 64'(log_q[b_or+3].rout), 64'h0008);
    chk("or_t3_yin", 64'(log_q[b_or+3].yin), 64'h1);
    chk("or_t4_alu", 64'(log_q[b_or+4].alu), 64'h06);
    chk("or_t4_rout", 64'(log_q[b_or+4].rout), 64'h0080);
    chk("or_t4_zli", 64'(log_q[b_or+4].zli), 64'h1);
    chk("or_t5_rin", 64'(log_q[b_or+5].rin), 64'h0010);
    chk("or_t5_zlo", 64'(log_q[b_or+5].zlo), 64'h1);
    chk("or_next_t0", 64'(log_q[b_or+6].pcout), 64'h1);
    chk("neg_t4_rout", 64'(log_q[b_neg+3].rout), 64'h0200);
    chk("neg_t4_alu", 64'(log_q[b_neg+3].alu), 64'h11);
    chk("neg_t5_rin", 64'(log_q[b_neg+4].rin), 64'h0020);
`ifdef CTRL_MULDIV_EN
    chk("mul_t5_lo", 64'(log_q[b_mul+5].loin), 64'h1);
    chk("mul_t5_rin", 64'(log_q[b_mul+5].rin), 64'h0);
    chk("mul_t6_hi", 64'(log_q[b_mul+6].hiin), 64'h1);
    chk("mul_t6_zho", 64'(log_q[b_mul+6].zho), 64'h1);
`else
    chk("mul_ill", 64'(log_q[b_mul+2].ill), 64'h1);
    chk("mul_next_t0", 64'(log_q[b_mul+3].pcout), 64'h1);
`endif
    chk("ill_t2", 64'(log_q[b_ill+2].ill), 64'h1);
    chk("ill_rin", 64'(log_q[b_ill+2].rin), 64'h0);
    chk("ill_pulse_end", 64'(log_q[b_ill+3].ill), 64'h0);
    chk("ill_next_t0", 64'(log_q[b_ill+3].pcout), 64'h1);
    chk("halt_run", 64'(log_q[b_h1+3].run), 64'h0);
    chk("halt_restart", 64'(log_q[b_not].pcout), 64'h1);
    chk("not_t5_rin", 64'(log_q[b_not+4].rin), 64'h0004);

    // Clear during T4 of an ADD
    bus.IR = 32'h18978000;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("clr_pre_t4", 64'(got.zli), 64'h1);
    #2 clr = 1'b1;
    #1 chk("clr_async", 64'(got), 64'h0);
    repeat (3) begin
      @(negedge clk);
      chk("clr_hold", 64'(got), 64'h0);
    end
    @(posedge clk);
    #1 clr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_after_clr", 64'(got), 64'h0);
    end
    @(posedge clk);
    #1 bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    @(negedge clk);
    chk("start_latency", 64'(got.pcout), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
